// File: rtl/struct_access_if.sv
// Valid/ready stream channel carrying one data word per handshake.
// Master drives data and valid; slave returns ready.
interface struct_access_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/struct_access.sv
// Extracts a fixed field from each struct and forks it, with the optional
// pass-through struct, onto two independently skid-buffered outputs.
module struct_access #(
  parameter int STRUCT_WIDTH  = 16,
  parameter int ACCESS_OFFSET = 0,
  parameter int ACCESS_SIZE   = 4,
  parameter int PASS_ENABLE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  struct_access_if.slave   s_struct_axis,
  struct_access_if.master  m_field_axis,
  struct_access_if.master  m_struct_axis
);

  localparam int SW = STRUCT_WIDTH;
  localparam int FW = ACCESS_SIZE;

  logic          tready_q;
  logic          acc;
  logic [FW-1:0] field_in;

  logic [FW-1:0] main_f, main_f_n;
  logic [FW-1:0] skid_f, skid_f_n;
  logic          main_f_valid, main_f_valid_n;
  logic          skid_f_valid, skid_f_valid_n;
  logic          drain_f;
  logic          skid_s_valid_n;

  assign acc = s_struct_axis.tvalid && tready_q;
  assign s_struct_axis.tready = tready_q;
  assign field_in =
    s_struct_axis.tdata[ACCESS_OFFSET +: FW];

  assign m_field_axis.tdata  = main_f;
  assign m_field_axis.tvalid = main_f_valid;
  assign drain_f = main_f_valid && m_field_axis.tready;

  always_comb begin
    main_f_n       = main_f;
    main_f_valid_n = main_f_valid;
    skid_f_n       = skid_f;
    skid_f_valid_n = skid_f_valid;
    if (acc) begin
      if (!main_f_valid || drain_f) begin
        main_f_n       = field_in;
        main_f_valid_n = 1'b1;
      end else begin
        skid_f_n       = field_in;
        skid_f_valid_n = 1'b1;
      end
    end else if (drain_f) begin
      if (skid_f_valid) begin
        main_f_n       = skid_f;
        main_f_valid_n = 1'b1;
        skid_f_valid_n = 1'b0;
      end else begin
        main_f_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_f       <= '0;
      main_f_valid <= 1'b0;
      skid_f       <= '0;
      skid_f_valid <= 1'b0;
    end else begin
      main_f       <= main_f_n;
      main_f_valid <= main_f_valid_n;
      skid_f       <= skid_f_n;
      skid_f_valid <= skid_f_valid_n;
    end
  end

  generate
    if (PASS_ENABLE != 0) begin : g_pass
      logic [SW-1:0] main_s, main_s_n;
      logic [SW-1:0] skid_s, skid_s_n;
      logic          main_s_valid, main_s_valid_n;
      logic          skid_s_valid;
      logic          drain_s;

      assign m_struct_axis.tdata  = main_s;
      assign m_struct_axis.tvalid = main_s_valid;
      assign drain_s = main_s_valid && m_struct_axis.tready;

      always_comb begin
        main_s_n       = main_s;
        main_s_valid_n = main_s_valid;
        skid_s_n       = skid_s;
        skid_s_valid_n = skid_s_valid;
        if (acc) begin
          if (!main_s_valid || drain_s) begin
            main_s_n       = s_struct_axis.tdata;
            main_s_valid_n = 1'b1;
          end else begin
            skid_s_n       = s_struct_axis.tdata;
            skid_s_valid_n = 1'b1;
          end
        end else if (drain_s) begin
          if (skid_s_valid) begin
            main_s_n       = skid_s;
            main_s_valid_n = 1'b1;
            skid_s_valid_n = 1'b0;
          end else begin
            main_s_valid_n = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_s       <= '0;
          main_s_valid <= 1'b0;
          skid_s       <= '0;
          skid_s_valid <= 1'b0;
        end else begin
          main_s       <= main_s_n;
          main_s_valid <= main_s_valid_n;
          skid_s       <= skid_s_n;
          skid_s_valid <= skid_s_valid_n;
        end
      end
    end else begin : g_nopass
      logic unused_in;
      assign unused_in = ^{s_struct_axis.tdata,
                           m_struct_axis.tready};
      assign skid_s_valid_n       = 1'b0;
      assign m_struct_axis.tdata  = '0;
      assign m_struct_axis.tvalid = 1'b0;
    end
  endgenerate

  // Ready only while both skids will be empty, so an accept never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tready_q <= 1'b0;
    else        tready_q <= !(skid_f_valid_n || skid_s_valid_n);
  end

endmodule

// File: tb/tb_struct_access.sv
// Scoreboard bench for struct_access: field/struct fork with skid buffers,
// plus a PASS_ENABLE=0 instance.
module tb_struct_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  struct_access_if #(.W(16)) s_if ();
  struct_access_if #(.W(4))  f_if ();
  struct_access_if #(.W(16)) m_if ();
  struct_access_if #(.W(16)) s0_if ();
  struct_access_if #(.W(4))  f0_if ();
  struct_access_if #(.W(16)) m0_if ();

  struct_access #(
    .STRUCT_WIDTH(16), .ACCESS_OFFSET(4),
    .ACCESS_SIZE(4), .PASS_ENABLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_struct_axis(s_if),
    .m_field_axis(f_if),
    .m_struct_axis(m_if)
  );

  struct_access #(
    .STRUCT_WIDTH(16), .ACCESS_OFFSET(4),
    .ACCESS_SIZE(4), .PASS_ENABLE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_struct_axis(s0_if),
    .m_field_axis(f0_if),
    .m_struct_axis(m0_if)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0]  qf[$];
  logic [3:0]  qf0[$];
  logic [15:0] qs[$];
  logic [3:0]  ef, ef0;
  logic [15:0] es;
  bit rnd = 0;

  function automatic logic [3:0] fld(input logic [15:0] d);
    return d[7:4];
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    while (s_if.tready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: data %h never accepted", d);
        s_if.tvalid = 1'b0;
        return;
      end
    end
    qf.push_back(fld(d));
    qs.push_back(d);
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send0(input logic [15:0] d);
    int n = 0;
    s0_if.tdata  = d;
    s0_if.tvalid = 1'b1;
    while (s0_if.tready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL send0_timeout: data %h never accepted", d);
        s0_if.tvalid = 1'b0;
        return;
      end
    end
    qf0.push_back(fld(d));
    @(negedge clk);
    s0_if.tvalid = 1'b0;
  endtask

  logic pf_v, pf_r, ps_v, ps_r;
  logic [3:0]  pf_d;
  logic [15:0] ps_d;

  // Monitors sample 1 time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && f_if.tvalid && f_if.tready) begin
      if (qf.size() == 0) begin
        checks++; errors++;
        $display("FAIL field_extra: got %h expected none", f_if.tdata);
      end else begin
        ef = qf.pop_front();
        chk("field_data", {28'd0, f_if.tdata}, {28'd0, ef});
      end
    end
    if (rst_n && m_if.tvalid && m_if.tready) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL struct_extra: got %h expected none", m_if.tdata);
      end else begin
        es = qs.pop_front();
        chk("struct_data", {16'd0, m_if.tdata}, {16'd0, es});
      end
    end
    if (rst_n && f0_if.tvalid && f0_if.tready) begin
      if (qf0.size() == 0) begin
        checks++; errors++;
        $display("FAIL p0_field_extra: got %h expected none", f0_if.tdata);
      end else begin
        ef0 = qf0.pop_front();
        chk("p0_field_data", {28'd0, f0_if.tdata}, {28'd0, ef0});
      end
    end
    if (rst_n && pf_v && !pf_r) begin
      chk("field_hold_valid", {31'd0, f_if.tvalid}, 32'd1);
      chk("field_hold_data", {28'd0, f_if.tdata}, {28'd0, pf_d});
    end
    if (rst_n && ps_v && !ps_r) begin
      chk("struct_hold_valid", {31'd0, m_if.tvalid}, 32'd1);
      chk("struct_hold_data", {16'd0, m_if.tdata}, {16'd0, ps_d});
    end
    if (rst_n && s_if.tvalid && s_if.tready) begin
      checks++;
      if (dut.skid_f_valid || dut.g_pass.skid_s_valid) begin
        errors++;
        $display("FAIL skid_on_accept: got skid_f=%b skid_s=%b expected 0",
                 dut.skid_f_valid, dut.g_pass.skid_s_valid);
      end
    end
    pf_v = rst_n && f_if.tvalid;
    pf_r = f_if.tready;
    pf_d = f_if.tdata;
    ps_v = rst_n && m_if.tvalid;
    ps_r = m_if.tready;
    ps_d = m_if.tdata;
  end

  always @(negedge clk) begin
    if (rnd) begin
      f_if.tready = 1'($urandom_range(0, 1));
      m_if.tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drain_wait();
    int n = 0;
    while ((qf.size() != 0 || qs.size() != 0 || qf0.size() != 0)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_field_q", qf.size(), 0);
    chk("drain_struct_q", qs.size(), 0);
    chk("drain_p0_q", qf0.size(), 0);
  endtask

  initial begin
    s_if.tdata = '0;  s_if.tvalid = 1'b0;
    s0_if.tdata = '0; s0_if.tvalid = 1'b0;
    f_if.tready = 1'b1;  m_if.tready = 1'b1;
    f0_if.tready = 1'b1; m0_if.tready = 1'b0;
    pf_v = 0; ps_v = 0; pf_r = 0; ps_r = 0;
    pf_d = '0; ps_d = '0;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_tready", {31'd0, s_if.tready}, 32'd0);
      chk("rst_fvalid", {31'd0, f_if.tvalid}, 32'd0);
      chk("rst_svalid", {31'd0, m_if.tvalid}, 32'd0);
      chk("rst_fdata", {28'd0, f_if.tdata}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("tready_after_rst", {31'd0, s_if.tready}, 32'd1);

    @(negedge clk);
    send(16'hABCD);
    #1;
    chk("first_fvalid", {31'd0, f_if.tvalid}, 32'd1);
    chk("first_field", {28'd0, f_if.tdata}, 32'hC);
    chk("first_struct", {16'd0, m_if.tdata}, 32'hABCD);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      chk("stream_tready", {31'd0, s_if.tready}, 32'd1);
      send(16'(i));
    end
    drain_wait();

    m_if.tready = 1'b0;
    f_if.tready = 1'b1;
    send(16'h0010);
    send(16'h0020);
    fork
      send(16'h0030);
      begin
        #1;
        chk("fork_tready_low", {31'd0, s_if.tready}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("fork_struct_hold", {16'd0, m_if.tdata}, 32'h0010);
        chk("fork_field_empty", {31'd0, f_if.tvalid}, 32'd0);
        chk("fork_tready_still", {31'd0, s_if.tready}, 32'd0);
        @(negedge clk);
        m_if.tready = 1'b1;
      end
    join
    drain_wait();

    rnd = 1;
    for (int i = 0; i < 100; i++) send(16'($urandom));
    @(negedge clk);
    rnd = 0;
    f_if.tready = 1'b1;
    m_if.tready = 1'b1;
    drain_wait();

    f_if.tready = 1'b0;
    m_if.tready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    #1;
    chk("skids_full_tready", {31'd0, s_if.tready}, 32'd0);
    #2;
    rst_n = 1'b0;
    qf.delete();
    qs.delete();
    #1;
    chk("midrst_fvalid", {31'd0, f_if.tvalid}, 32'd0);
    chk("midrst_svalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("midrst_tready", {31'd0, s_if.tready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f_if.tready = 1'b1;
    m_if.tready = 1'b1;
    @(negedge clk);
    send(16'h5A5A);
    #1;
    chk("post_rst_field", {28'd0, f_if.tdata}, 32'h5);
    chk("post_rst_struct", {16'd0, m_if.tdata}, 32'h5A5A);
    @(negedge clk);
    drain_wait();

    for (int i = 0; i < 8; i++) begin
      #1;
      chk("p0_tready", {31'd0, s0_if.tready}, 32'd1);
      chk("p0_svalid", {31'd0, m0_if.tvalid}, 32'd0);
      @(negedge clk);
      send0(16'h0100 + 16'(i * 16'h0011));
    end
    #1;
    chk("p0_svalid_end", {31'd0, m0_if.tvalid}, 32'd0);
    @(negedge clk);
    drain_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
